// File: rtl/serial_adder_if.sv
// serial_adder_if: groups the start/done handshake, operand and result signals
// of serial_adder.
//
// Signals:
//   start  request; sampled by the adder only in IDLE or DONE
//   a, b   WIDTH-bit operands, captured on an accepted start
//   cin    carry in, captured on an accepted start
//   busy   high while the adder is in RUN
//   done   one-cycle pulse when the result is valid
//   sum    WIDTH-bit result, held until the next accepted start
//   cout   final carry out, held with sum
//   ovf    signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
// Modports:
//   master  requester side: drives start/a/b/cin, observes the result
//   slave   adder side
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf signal.

interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder. Two WIDTH-bit operands and a carry
// in are captured on an accepted start and then summed one bit per clock, LSB
// first, through a single full-add cell with a registered carry. After WIDTH
// RUN cycles the result is published and done pulses for one cycle.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   reset  synchronous, active-high reset; wins over every other input
//   bus    serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout out
//
// Parameters:
//   WIDTH  operand and sum width, legal range 2..32
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   Defined:   bus.ovf = two's-complement overflow (carry into MSB ^ cout),
//              with the same reset, update and hold behaviour as cout.
//   Undefined: no ovf signal and no ovf register.
//
// Timing: start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH and
// done=1 in cycle k+WIDTH+1. Holding start in DONE reloads immediately, so
// back-to-back operation sustains one add per WIDTH+1 cycles.

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  serial_adder_if.slave bus
);

  // Wide enough to hold WIDTH-1 without ever wrapping inside an operation.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  // Single full-add cell on the current LSB pair and the registered carry.
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] sum_sr_shift;

  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sr_shift = {bit_s, sum_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end
      end

      StRun: begin
        // Operand inputs and start are deliberately ignored here.
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_sr_shift;
        carry_d  = bit_c;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = sum_sr_shift;
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last bit carry_q is the carry into the MSB stage.
          ovf_d   = carry_q ^ bit_c;
`endif
        end
      end

      StDone: begin
        if (bus.start) begin
          state_d = StRun;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8). Expected
// results come from plain a+b+cin arithmetic; expected timing comes from the
// start/busy/done latency rules.

module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are driven and outputs
  // sampled there, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                         input logic ci);
    return {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
  endfunction

  // Signed overflow: both operands share a sign that the result does not.
  function automatic logic ref_ovf(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ci);
    logic [W:0] r;
    r = ref_sum(aa, bb, ci);
    return (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                              input logic ci);
    logic [W:0] r;
    r = ref_sum(aa, bb, ci);
    check({tag, ".sum"}, 64'(bus.sum), 64'(r[W-1:0]));
    check({tag, ".cout"}, 64'(bus.cout), 64'(r[W]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(ref_ovf(aa, bb, ci)));
`endif
  endtask

  // One complete operation with a one-cycle start. With scramble set, the
  // operand inputs and start are randomised during RUN and must be ignored.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                        input bit scramble, input string tag);
    bus.start = 1'b1;
    bus.a     = aa;
    bus.b     = bb;
    bus.cin   = ci;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (scramble) begin
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        bus.start = 1'($urandom);
      end
      check({tag, ".busy_run"}, 64'(bus.busy), 64'(1));
      check({tag, ".done_run"}, 64'(bus.done), 64'(0));
      tick();
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 64'(bus.done), 64'(1));
    check({tag, ".busy_done"}, 64'(bus.busy), 64'(0));
    check_result(tag, aa, bb, ci);
    tick();
    check({tag, ".done_once"}, 64'(bus.done), 64'(0));
    check({tag, ".busy_after"}, 64'(bus.busy), 64'(0));
    check_result({tag, ".hold"}, aa, bb, ci);
  endtask

  logic [W-1:0] b2b_a[3];
  logic [W-1:0] b2b_b[3];
  logic         b2b_c[3];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.done", 64'(bus.done), 64'(0));
    check("rst.sum", 64'(bus.sum), 64'(0));
    check("rst.cout", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("rst.ovf", 64'(bus.ovf), 64'(0));
`endif
    tick();
    check("idle.done", 64'(bus.done), 64'(0));

    // Directed operand patterns.
    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, "t1");
    check("t1.const_sum", 64'(bus.sum), 64'(8'h96));
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "t2a");
    check("t2a.const_cout", 64'(bus.cout), 64'(1));
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "t2b");
    check("t2b.const_sum", 64'(bus.sum), 64'(8'hFF));

    // Second start and operand change during RUN are ignored; done arrives
    // exactly W+1 cycles after the accepted start.
    bus.start = 1'b1;
    bus.a     = 8'h81;
    bus.b     = 8'h42;
    bus.cin   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cin   = 1'b0;
      end
      check("t3.busy", 64'(bus.busy), 64'(1));
      check("t3.done_early", 64'(bus.done), 64'(0));
      tick();
    end
    bus.start = 1'b0;
    check("t3.done", 64'(bus.done), 64'(1));
    check_result("t3", 8'h81, 8'h42, 1'b1);
    tick();
    check("t3.idle", 64'(bus.busy), 64'(0));

    // Back-to-back with start held high; next operands presented during RUN.
    b2b_a[0] = 8'h12; b2b_b[0] = 8'h34; b2b_c[0] = 1'b0;
    b2b_a[1] = 8'h80; b2b_b[1] = 8'h80; b2b_c[1] = 1'b1;
    b2b_a[2] = 8'h7F; b2b_b[2] = 8'h01; b2b_c[2] = 1'b0;
    bus.start = 1'b1;
    bus.a     = b2b_a[0];
    bus.b     = b2b_b[0];
    bus.cin   = b2b_c[0];
    tick();
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (i == 0 && j < 2) begin
          bus.a   = b2b_a[j+1];
          bus.b   = b2b_b[j+1];
          bus.cin = b2b_c[j+1];
        end
        check("t4.busy", 64'(bus.busy), 64'(1));
        check("t4.done_early", 64'(bus.done), 64'(0));
        tick();
      end
      if (j == 2) bus.start = 1'b0;
      check("t4.done", 64'(bus.done), 64'(1));
      check("t4.busy_low", 64'(bus.busy), 64'(0));
      check_result("t4", b2b_a[j], b2b_b[j], b2b_c[j]);
      tick();
    end
    check("t4.end_busy", 64'(bus.busy), 64'(0));
    check("t4.end_done", 64'(bus.done), 64'(0));

    // Reset in the middle of RUN aborts and clears the held result.
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h11;
    bus.cin   = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("t5.busy_pre", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.busy", 64'(bus.busy), 64'(0));
    check("t5.done", 64'(bus.done), 64'(0));
    check("t5.sum", 64'(bus.sum), 64'(0));
    check("t5.cout", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("t5.ovf", 64'(bus.ovf), 64'(0));
`endif
    tick();
    check("t5.no_done", 64'(bus.done), 64'(0));
    run_op(8'h01, 8'h01, 1'b0, 1'b0, "t5r");
    check("t5r.const_sum", 64'(bus.sum), 64'(8'h02));

    // Random operations with noisy inputs during RUN and random idle gaps.
    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "rnd");
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
